// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// ICTRL/ICAUSE bit positions and the request/service state encoding.
package intc_pkg;

    localparam int unsigned INTC_OFF_PEND  = 0;
    localparam int unsigned INTC_OFF_MASK  = 2;
    localparam int unsigned INTC_OFF_CTRL  = 4;
    localparam int unsigned INTC_OFF_CAUSE = 6;

    localparam int unsigned INTC_CTRL_GIE    = 0;
    localparam int unsigned INTC_CTRL_INSV   = 1;
    localparam int unsigned INTC_CAUSE_VALID = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } intc_state_t;

endpackage

// File: rtl/intr_ctl_if.sv
// Bus-side address/strobe/write-data bundle of the interrupt controller.
// The bus master drives everything; the controller only listens.
interface intr_ctl_if #(
    parameter int ABITS = 32,
    parameter int DBITS = 32
);
    logic [ABITS-1:0] ABUS;
    logic             RE;
    logic             WE;
    logic [DBITS-1:0] WBUS;

    modport master (output ABUS, RE, WE, WBUS);
    modport slave  (input  ABUS, RE, WE, WBUS);
endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder: idx_o is the lowest set bit of req_i
// (0 when nothing is set), any_o flags that at least one bit is set.
module intc_prio_enc #(
    parameter int NSRC  = 4,
    parameter int CBITS = 4
) (
    input  logic [NSRC-1:0]  req_i,
    output logic [CBITS-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        idx_o = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = CBITS'(i);
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/intr_ctl.sv
// Memory-mapped interrupt controller: registers the device INTR lines,
// applies mask and global enable, raises IRQ for the highest-priority
// source and tracks the IACK / EOI handshake.
// Optional build macro INTC_EDGE_LATCH_EN: IPEND latches rising edges of
// the registered sources (write-1-to-clear) instead of following them.
module intr_ctl
    import intc_pkg::*;
#(
    parameter int          ABITS = 32,
    parameter int          DBITS = 32,
    parameter int unsigned RBASE = 32'h000F_0000,
    parameter int          NSRC  = 4,
    parameter int          CBITS = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             LOCK,
    intr_ctl_if.slave        bus,
    // Kept as a plain inout so the tri-state driver sits on the module boundary.
    inout  wire  [DBITS-1:0] RBUS,
    input  logic [NSRC-1:0]  SRC,
    output logic             IRQ,
    input  logic             IACK,
    output logic [CBITS-1:0] CAUSE
);

    logic sel_pend, sel_mask, sel_ctrl, sel_cause, sel_any, wr_ok;

    assign sel_pend  = (bus.ABUS == ABITS'(RBASE + INTC_OFF_PEND));
    assign sel_mask  = (bus.ABUS == ABITS'(RBASE + INTC_OFF_MASK));
    assign sel_ctrl  = (bus.ABUS == ABITS'(RBASE + INTC_OFF_CTRL));
    assign sel_cause = (bus.ABUS == ABITS'(RBASE + INTC_OFF_CAUSE));
    assign sel_any   = sel_pend | sel_mask | sel_ctrl | sel_cause;
    // Bus writes are dropped while the PLL is unlocked.
    assign wr_ok     = bus.WE & LOCK;

    intc_state_t      state_q, state_d;
    logic [NSRC-1:0]  src_q;
    logic [NSRC-1:0]  imask_q, imask_d;
    logic             gie_q, gie_d;
    logic             insv_q, insv_d;
    logic [CBITS-1:0] cause_q, cause_d;
    logic [NSRC-1:0]  pend_w, elig_w;
    logic [CBITS-1:0] best_w;
    logic             any_w;

`ifdef INTC_EDGE_LATCH_EN
    logic [NSRC-1:0] src_d1_q, ipend_q, ipend_d;

    // Latched pending bits: software clear first, so a new edge in the same cycle wins.
    always_comb begin
        ipend_d = ipend_q;
        if (wr_ok && sel_pend) ipend_d = ipend_d & ~bus.WBUS[NSRC-1:0];
        ipend_d = ipend_d | (src_q & ~src_d1_q);
    end

    // Edge-detect history and latched pending register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            src_d1_q <= '0;
            ipend_q  <= '0;
        end else if (LOCK) begin
            src_d1_q <= src_q;
            ipend_q  <= ipend_d;
        end
    end

    assign pend_w = ipend_q;
`else
    assign pend_w = src_q;
`endif

    assign elig_w = pend_w & imask_q & {NSRC{gie_q}};

    intc_prio_enc #(
        .NSRC  (NSRC),
        .CBITS (CBITS)
    ) u_prio (
        .req_i (elig_w),
        .idx_o (best_w),
        .any_o (any_w)
    );

    // Next-state logic for the handshake FSM and the software registers.
    always_comb begin
        state_d = state_q;
        imask_d = imask_q;
        gie_d   = gie_q;
        insv_d  = insv_q;
        cause_d = cause_q;
        IRQ     = 1'b0;
        if (wr_ok && sel_mask) imask_d = bus.WBUS[NSRC-1:0];
        if (wr_ok && sel_ctrl) gie_d = bus.WBUS[INTC_CTRL_GIE];
        case (state_q)
            IDLE: begin
                if (any_w) state_d = REQ;
            end
            REQ: begin
                IRQ = 1'b1;
                if (!any_w) begin
                    state_d = IDLE;
                end else if (IACK) begin
                    cause_d = best_w;
                    insv_d  = 1'b1;
                    state_d = SERV;
                end
            end
            SERV: begin
                // EOI is an ICTRL write with INSV=0; it takes priority over IACK.
                if (wr_ok && sel_ctrl && !bus.WBUS[INTC_CTRL_INSV]) begin
                    insv_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register update; everything freezes while LOCK is low.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            src_q   <= '0;
            imask_q <= '0;
            gie_q   <= 1'b0;
            insv_q  <= 1'b0;
            cause_q <= '0;
        end else if (LOCK) begin
            state_q <= state_d;
            src_q   <= SRC;
            imask_q <= imask_d;
            gie_q   <= gie_d;
            insv_q  <= insv_d;
            cause_q <= cause_d;
        end
    end

    logic [DBITS-1:0] rdata_w;

    // Combinational register read mux, zero-extended to the bus width.
    always_comb begin
        rdata_w = '0;
        if (sel_pend) begin
            rdata_w[NSRC-1:0] = pend_w;
        end else if (sel_mask) begin
            rdata_w[NSRC-1:0] = imask_q;
        end else if (sel_ctrl) begin
            rdata_w[INTC_CTRL_GIE]  = gie_q;
            rdata_w[INTC_CTRL_INSV] = insv_q;
        end else if (sel_cause) begin
            rdata_w[INTC_CAUSE_VALID] = insv_q;
            rdata_w[CBITS-1:0]        = cause_q;
        end
    end

    assign RBUS  = (bus.RE && sel_any) ? rdata_w : {DBITS{1'bz}};
    assign CAUSE = cause_q;

    // Upper write-data bits have no destination register.
    logic unused_wbus;
    assign unused_wbus = ^bus.WBUS;

endmodule

// File: tb/tb_intr_ctl.sv
// Scoreboard bench for intr_ctl: a cycle-level behavioural model predicts
// IRQ, CAUSE and read data for every driven cycle; a monitor compares.
module tb_intr_ctl;
    import intc_pkg::*;

    localparam int unsigned RBASE = 32'h000F_0000;

    logic        clk = 1'b0;
    logic        rst_n, lock, iack;
    logic [3:0]  src;
    logic        irq;
    logic [3:0]  cause;
    wire  [31:0] rbus;

    always #5 clk = ~clk;

    intr_ctl_if #(.ABITS(32), .DBITS(32)) bus ();

    intr_ctl #(
        .ABITS(32), .DBITS(32), .RBASE(RBASE), .NSRC(4), .CBITS(4)
    ) dut (
        .CLK(clk), .RESETN(rst_n), .LOCK(lock), .bus(bus), .RBUS(rbus),
        .SRC(src), .IRQ(irq), .IACK(iack), .CAUSE(cause)
    );

    typedef struct {
        int          id;
        logic        irq;
        logic [3:0]  cause;
        logic        rd_chk;
        logic [2:0]  off;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   txn     = 0;

    // ---------------- behavioural reference model ----------------
    logic [3:0] m_src, m_mask, m_cause;
    logic       m_gie, m_insv;
    int         m_phase;   // 0 waiting, 1 requesting, 2 in service
`ifdef INTC_EDGE_LATCH_EN
    logic [3:0] m_pend, m_prev;
`endif
    logic [3:0] cur_src = 4'h0;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] m_view();
`ifdef INTC_EDGE_LATCH_EN
        return m_pend;
`else
        return m_src;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (int'(off))
            INTC_OFF_PEND:  return {28'd0, m_view()};
            INTC_OFF_MASK:  return {28'd0, m_mask};
            INTC_OFF_CTRL:  return {30'd0, m_insv, m_gie};
            INTC_OFF_CAUSE: return {16'd0, m_insv, 11'd0, m_cause};
            default:        return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_src = 0; m_mask = 0; m_cause = 0; m_gie = 0; m_insv = 0; m_phase = 0;
`ifdef INTC_EDGE_LATCH_EN
        m_pend = 0; m_prev = 0;
`endif
    endtask

    task automatic model_tick(input logic [3:0] s, input logic ia, input logic we,
                              input logic [2:0] off, input logic [31:0] wd);
        logic [3:0] elig;
        elig = m_view() & m_mask & {4{m_gie}};
        case (m_phase)
            0: if (elig != 0) m_phase = 1;
            1: begin
                if (elig == 0) m_phase = 0;
                else if (ia) begin
                    m_cause = 4'(lowest(elig));
                    m_insv  = 1'b1;
                    m_phase = 2;
                end
            end
            default: if (we && int'(off) == INTC_OFF_CTRL && !wd[1]) begin
                m_insv  = 1'b0;
                m_phase = 0;
            end
        endcase
`ifdef INTC_EDGE_LATCH_EN
        if (we && int'(off) == INTC_OFF_PEND) m_pend = m_pend & ~wd[3:0];
        m_pend = m_pend | (m_src & ~m_prev);
        m_prev = m_src;
`endif
        if (we && int'(off) == INTC_OFF_MASK) m_mask = wd[3:0];
        if (we && int'(off) == INTC_OFF_CTRL) m_gie = wd[0];
        m_src = s;
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input logic rn, input logic lk, input logic [3:0] s, input logic ia,
                        input logic re, input logic we, input logic [2:0] off,
                        input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        rst_n = rn; lock = lk; src = s; iack = ia;
        bus.RE = re; bus.WE = we; bus.ABUS = RBASE + 32'(off); bus.WBUS = wd;
        if (!rn) model_reset();
        e.id = txn; e.irq = (m_phase == 1); e.cause = m_cause;
        e.rd_chk = re && !off[0]; e.off = off; e.rd = m_read(off);
        sb.push_back(e);
        txn++;
        if (rn && lk) model_tick(s, ia, we, off, wd);
    endtask

    task automatic cyc(input logic ia);
        step(1'b1, 1'b1, cur_src, ia, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask
    task automatic wr(input int off, input logic [31:0] d);
        step(1'b1, 1'b1, cur_src, 1'b0, 1'b0, 1'b1, 3'(off), d);
    endtask
    task automatic rd(input int off);
        step(1'b1, 1'b1, cur_src, 1'b0, 1'b1, 1'b0, 3'(off), 32'd0);
    endtask
    task automatic wait_req();
        for (int i = 0; i < 8 && m_phase != 1; i++) cyc(1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("irq#%0d", e.id), {31'd0, irq}, {31'd0, e.irq});
                check($sformatf("cause#%0d", e.id), {28'd0, cause}, {28'd0, e.cause});
                if (e.rd_chk) begin
                    check($sformatf("rbus#%0d off%0d", e.id, e.off), rbus, e.rd);
                    $display("[TB] txn %0d read off=%0d data=0x%08h irq=%0b cause=%0d",
                             e.id, e.off, rbus, irq, cause);
                end
            end
        end
    end

    // ---------------- directed then random sequence ----------------
    initial begin : driver
        rst_n = 1'b1; lock = 1'b1; src = 4'h0; iack = 1'b0;
        bus.RE = 1'b0; bus.WE = 1'b0; bus.ABUS = RBASE; bus.WBUS = 32'd0;
        model_reset();

        // Reset values
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 3'(INTC_OFF_CAUSE), 32'd0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        rd(INTC_OFF_PEND); rd(INTC_OFF_MASK); rd(INTC_OFF_CTRL); rd(INTC_OFF_CAUSE);

        // Basic request and acknowledge of source 2
        wr(INTC_OFF_MASK, 32'hF); wr(INTC_OFF_CTRL, 32'h1);
        cur_src = 4'b0100; cyc(1'b0); cyc(1'b0); wait_req(); cyc(1'b1);
        rd(INTC_OFF_CAUSE); rd(INTC_OFF_CTRL);

        // Reset while in service clears everything at once
        step(1'b0, 1'b1, cur_src, 1'b0, 1'b1, 1'b0, 3'(INTC_OFF_CAUSE), 32'd0);
        step(1'b0, 1'b1, cur_src, 1'b0, 1'b1, 1'b0, 3'(INTC_OFF_CTRL), 32'd0);
        rd(INTC_OFF_CTRL);

        // Priority: 0b1010 resolves to 1, then 0b1000 to 3
        wr(INTC_OFF_MASK, 32'hF); wr(INTC_OFF_CTRL, 32'h1);
        cur_src = 4'b1010; wait_req(); cyc(1'b1); rd(INTC_OFF_CAUSE);
        cur_src = 4'b1000; wr(INTC_OFF_CTRL, 32'h1); wait_req(); cyc(1'b1);
        rd(INTC_OFF_CAUSE); wr(INTC_OFF_CTRL, 32'h1); rd(INTC_OFF_CAUSE);

        // Masking
        cur_src = 4'h0; wr(INTC_OFF_MASK, 32'h7); cur_src = 4'b1000;
        repeat (4) cyc(1'b0);
        wr(INTC_OFF_MASK, 32'hF); wait_req(); rd(INTC_OFF_CTRL);
        cur_src = 4'h0; repeat (3) cyc(1'b0);

        // Source drops during request; late IACK ignored
        cur_src = 4'b0001; wait_req(); cur_src = 4'h0;
        cyc(1'b0); cyc(1'b1); rd(INTC_OFF_CTRL); rd(INTC_OFF_CAUSE);

        // Pulse latching and clear/set collision
        cur_src = 4'h0; repeat (3) cyc(1'b0);
        cur_src = 4'h1; cyc(1'b0); cur_src = 4'h0;
        repeat (3) rd(INTC_OFF_PEND);
        wr(INTC_OFF_PEND, 32'h1); rd(INTC_OFF_PEND);
        cur_src = 4'h1; cyc(1'b0); cur_src = 4'h0;
        wr(INTC_OFF_PEND, 32'h1); rd(INTC_OFF_PEND); rd(INTC_OFF_PEND);

        // LOCK low freezes state and drops writes
        wr(INTC_OFF_CTRL, 32'h1);
        step(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 3'(INTC_OFF_MASK), 32'h0);
        step(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 3'(INTC_OFF_MASK), 32'h0);
        rd(INTC_OFF_MASK);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            int       op;
            logic     ia;
            logic [2:0] off;
            if ($urandom_range(0, 3) == 0) cur_src = 4'($urandom);
            ia  = ($urandom_range(0, 2) == 0);
            op  = int'($urandom_range(0, 15));
            off = 3'(2 * $urandom_range(0, 3));
            case (op)
                0, 1, 2, 3, 4: step(1'b1, 1'b1, cur_src, ia, 1'b1, 1'b0, off, 32'd0);
                5: step(1'b1, 1'b1, cur_src, ia, 1'b0, 1'b1, 3'(INTC_OFF_MASK), $urandom);
                6: step(1'b1, 1'b1, cur_src, ia, 1'b1, 1'b1, 3'(INTC_OFF_CTRL),
                        {30'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0)});
                7: step(1'b1, 1'b1, cur_src, ia, 1'b0, 1'b1, 3'(INTC_OFF_PEND), $urandom);
                8: step(1'b1, 1'b1, cur_src, ia, 1'b0, 1'b1, 3'($urandom), $urandom);
                9: step(1'b1, 1'b0, cur_src, ia, 1'b1, 1'b1, off, $urandom);
                10: step(($urandom_range(0, 30) != 0), 1'b1, cur_src, ia, 1'b1, 1'b0, off, 32'd0);
                default: step(1'b1, 1'b1, cur_src, ia, 1'b0, 1'b0, 3'd0, 32'd0);
            endcase
        end

        @(negedge clk);
        #4;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d expected responses left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
